// File: rtl/fletcher_pkg.sv
// Shared types and arithmetic for the Fletcher-16x2 framer.
// mod_add folds the end-around carry so results stay in 0..65534.
package fletcher_pkg;

    typedef enum logic [1:0] {
        DATA    = 2'd0,
        TRAIL_B = 2'd1,
        TRAIL_A = 2'd2
    } state_t;

    localparam logic [15:0] MODULUS = 16'hFFFF;

    function automatic logic [15:0] mod_add(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] sum;
        logic [15:0] folded;
        sum    = {1'b0, x} + {1'b0, y};
        folded = sum[15:0] + {15'd0, sum[16]};
        // 0xFFFF is congruent to zero; never let it escape as a checksum value
        return (folded == MODULUS) ? 16'h0000 : folded;
    endfunction

endpackage

// File: rtl/fletcher16x2_accum.sv
// Running Fletcher a/b sums over 16-bit words, modulo 65535.
// b folds in the already-updated a on the same edge.
module fletcher16x2_accum
    import fletcher_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clear,
    input  logic [15:0] din,
    output logic [15:0] a,
    output logic [15:0] b
);

    logic [15:0] a_next;

    assign a_next = mod_add(a, din);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= 16'h0000;
            b <= 16'h0000;
        end else if (clear) begin
            a <= 16'h0000;
            b <= 16'h0000;
        end else if (en) begin
            a <= a_next;
            b <= mod_add(b, a_next);
        end
    end

endmodule

// File: rtl/fletcher_framer.sv
// Streams WordCount payload words through a one-word output register,
// then appends the Fletcher b and a trailer words (a marked last).
module fletcher_framer
    import fletcher_pkg::*;
#(
    parameter int WordCount = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last
);

    state_t      state;
    logic [15:0] count;
    logic [15:0] a;
    logic [15:0] b;
    logic        slot_free;
    logic        accept;
    logic        last_word;
    logic        trail_done;

    assign slot_free  = !dout_valid || dout_ready;
    assign din_ready  = (state == DATA) && slot_free && !clr;
    assign accept     = din_valid && din_ready;
    assign last_word  = (count == 16'(WordCount - 1));
    assign trail_done = (state == TRAIL_A) && slot_free && !clr;

    fletcher16x2_accum u_accum (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .clear (clr || trail_done),
        .din   (din),
        .a     (a),
        .b     (b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= DATA;
            count      <= 16'd0;
            dout       <= 16'h0000;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else if (clr) begin
            state      <= DATA;
            count      <= 16'd0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            case (state)
                DATA: begin
                    if (accept) begin
                        dout       <= din;
                        dout_valid <= 1'b1;
                        dout_last  <= 1'b0;
                        count      <= count + 16'd1;
                        if (last_word) begin
                            state <= TRAIL_B;
                        end
                    end else if (dout_ready) begin
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                    end
                end
                TRAIL_B: begin
                    // b already includes the final payload word here
                    if (slot_free) begin
                        dout       <= b;
                        dout_valid <= 1'b1;
                        dout_last  <= 1'b0;
                        state      <= TRAIL_A;
                    end
                end
                TRAIL_A: begin
                    if (slot_free) begin
                        dout       <= a;
                        dout_valid <= 1'b1;
                        dout_last  <= 1'b1;
                        count      <= 16'd0;
                        state      <= DATA;
                    end
                end
                default: begin
                    state <= DATA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fletcher_framer.sv
// Self-checking bench: two framers (2 and 4 words per frame) share stimulus;
// outputs of the selected one are checked against a queue-based Fletcher model.
module tb_fletcher_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [15:0] din;
    logic        din_valid;
    logic        dout_ready;
    logic        sel;

    logic        d2_din_ready, d2_dout_valid, d2_dout_last;
    logic [15:0] d2_dout;
    logic        d4_din_ready, d4_dout_valid, d4_dout_last;
    logic [15:0] d4_dout;

    logic        o_din_ready, o_dout_valid, o_dout_last;
    logic [15:0] o_dout;

    int vectors     = 0;
    int miscompares = 0;

    int src[$];
    int frm[$];
    int exp_w[$];
    int exp_l[$];

    always #5 clk = ~clk;

    fletcher_framer #(.WordCount(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
        .din_ready(d2_din_ready), .dout(d2_dout), .dout_valid(d2_dout_valid),
        .dout_ready(dout_ready), .dout_last(d2_dout_last)
    );

    fletcher_framer #(.WordCount(4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
        .din_ready(d4_din_ready), .dout(d4_dout), .dout_valid(d4_dout_valid),
        .dout_ready(dout_ready), .dout_last(d4_dout_last)
    );

    assign o_din_ready  = sel ? d4_din_ready  : d2_din_ready;
    assign o_dout       = sel ? d4_dout       : d2_dout;
    assign o_dout_valid = sel ? d4_dout_valid : d2_dout_valid;
    assign o_dout_last  = sel ? d4_dout_last  : d2_dout_last;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fletcher reference: a is the running word sum, b the sum of running a's.
    task automatic add_frame();
        int a = 0;
        int b = 0;
        while (frm.size() > 0) begin
            int w = frm.pop_front();
            src.push_back(w);
            exp_w.push_back(w);
            exp_l.push_back(0);
            a = (a + w) % 65535;
            b = (b + a) % 65535;
        end
        exp_w.push_back(b); exp_l.push_back(0);
        exp_w.push_back(a); exp_l.push_back(1);
    endtask

    function automatic int rand_word();
        return ($urandom_range(0, 7) == 0) ? 32'h0000FFFF : int'($urandom_range(0, 65535));
    endfunction

    task automatic rand_frames(input int nframes, input int nwords);
        for (int f = 0; f < nframes; f++) begin
            for (int i = 0; i < nwords; i++) frm.push_back(rand_word());
            add_frame();
        end
    endtask

    // mode 0: always valid/ready; 1: random gaps/backpressure; 2: 3-cycle stall at stall_at
    task automatic run(input int mode, input int stall_at, input int exp_cycles);
        int          cycles = 0;
        bit          took = 0, pend = 0, hold = 0;
        logic [15:0] pw = 16'h0, hd = 16'h0;
        logic        hl = 1'b0;
        while (exp_w.size() > 0 && cycles < 400) begin
            @(negedge clk);
            din_valid = (src.size() > 0) && (mode != 1 || $urandom_range(0, 3) != 0);
            din = (src.size() > 0) ? 16'(src[0]) : 16'($urandom);
            if (mode == 1) dout_ready = ($urandom_range(0, 2) != 0);
            else if (mode == 2) dout_ready = !(cycles >= stall_at && cycles < stall_at + 3);
            else dout_ready = 1'b1;
            #1;
            if (pend) begin
                check("pass_data", int'(o_dout), int'(pw));
                check("pass_valid", int'(o_dout_valid), 1);
            end
            if (hold) begin
                check("hold_data", int'(o_dout), int'(hd));
                check("hold_valid", int'(o_dout_valid), 1);
                check("hold_last", int'(o_dout_last), int'(hl));
            end
            if (mode == 2 && !dout_ready) check("stall_din_ready", int'(o_din_ready), 0);
            if (o_dout_valid && dout_ready) begin
                $display("out word %04h last=%0d (expect %04h last=%0d)", o_dout, o_dout_last, exp_w[0], exp_l[0]);
                check("dout", int'(o_dout), exp_w[0]);
                check("dout_last", int'(o_dout_last), exp_l[0]);
                void'(exp_w.pop_front());
                void'(exp_l.pop_front());
            end
            took = din_valid && o_din_ready;
            pend = took;
            pw   = din;
            hold = o_dout_valid && !dout_ready;
            hd   = o_dout;
            hl   = o_dout_last;
            @(posedge clk);
            cycles++;
            if (took) void'(src.pop_front());
        end
        check("drain", exp_w.size(), 0);
        if (exp_cycles > 0) check("cycles", cycles, exp_cycles);
        exp_w.delete(); exp_l.delete(); src.delete();
        @(negedge clk);
        din_valid  = 1'b0;
        dout_ready = 1'b1;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1; din_valid = 1'b0; dout_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; din = 16'h0; din_valid = 1'b0; dout_ready = 1'b0; sel = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_dout", int'(o_dout), 0);
            check("rst_valid", int'(o_dout_valid), 0);
            check("rst_last", int'(o_dout_last), 0);
            check("rst_din_ready", int'(o_din_ready), 1);
        end
        @(negedge clk);
        rst = 1'b0;

        // WordCount=2 directed frames, then back-to-back and random traffic
        sel = 1'b0;
        do_clr();
        frm = '{1, 2};           add_frame(); run(0, 0, 5);
        frm = '{65535, 65535};   add_frame(); run(0, 0, 5);
        frm = '{65534, 2};       add_frame(); run(0, 0, 5);
        rand_frames(2, 2);       run(0, 0, 9);
        rand_frames(4, 2);       run(1, 0, 0);

        // WordCount=4 with a mid-frame output stall, then random traffic
        sel = 1'b1;
        do_clr();
        rand_frames(1, 4);       run(2, 2, 0);
        rand_frames(3, 4);       run(1, 0, 0);

        // asynchronous reset after word 2 of 4, then a fresh frame
        do_clr();
        @(negedge clk); din_valid = 1'b1; din = 16'($urandom); dout_ready = 1'b1;
        @(negedge clk); din = 16'($urandom);
        @(negedge clk); din_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", int'(o_dout_valid), 0);
        check("async_rst_dout", int'(o_dout), 0);
        check("async_rst_last", int'(o_dout_last), 0);
        @(negedge clk); rst = 1'b0;
        frm = '{1, 2, 3, 4};     add_frame(); run(0, 0, 7);

        // clr while sitting in the b-trailer state with din_valid high
        sel = 1'b0;
        do_clr();
        @(negedge clk); din_valid = 1'b1; din = 16'($urandom); dout_ready = 1'b1;
        @(negedge clk); din = 16'($urandom);
        @(negedge clk); din_valid = 1'b0; dout_ready = 1'b0;
        @(negedge clk); clr = 1'b1; din_valid = 1'b1; din = 16'($urandom);
        #1;
        check("clr_din_ready", int'(o_din_ready), 0);
        @(negedge clk); clr = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
        #1;
        check("clr_valid", int'(o_dout_valid), 0);
        check("clr_last", int'(o_dout_last), 0);
        repeat (4) begin
            @(negedge clk);
            #1;
            check("clr_no_trailer", int'(o_dout_valid), 0);
        end
        rand_frames(1, 2);       run(0, 0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
